// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - row-scanned keypad with per-key debounce and a press/release event FIFO
// Optional KEY_SCAN_RELEASE_EN: when defined, release transitions are queued as events too.
module key_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_INTV  = 100_000,
  parameter int DEB_SCANS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [ROWS-1:0]                 row_drv,
  input  logic [COLS-1:0]                 col_in,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_release,
  output logic [ROWS*COLS-1:0]            key_state,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = $clog2(NK);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = $clog2(SCAN_INTV);
  localparam int CW  = $clog2(DEB_SCANS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic {DRIVE, EVAL} state_e;

  state_e           state_q, state_d;
  logic             started_q;
  logic [RW-1:0]    row_q, row_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [COLS-1:0]  raw_q, raw_d;
  logic [COLS-1:0]  sync1_q, sync2_q;
  logic [NK-1:0]    map_q, map_d;
  logic [CW-1:0]    cnt_q [NK];
  logic [CW-1:0]    cnt_d [NK];
  logic [KW-1:0]    k_idx;

  logic             push;
  logic             pop;
  logic             full;
  logic             do_push;
  logic [KW-1:0]    fcode_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      level_q;
  logic             ovf_q;
`ifdef KEY_SCAN_RELEASE_EN
  logic             push_rel;
  logic             frel_q [FIFO_DEPTH];
`endif

  assign k_idx = KW'(int'(row_q) * COLS + int'(col_q));

  // Rows stay released until the first cycle after reset so row 0 gets a full dwell.
  assign row_drv = started_q ? ~(ROWS'(1) << row_q) : '1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    col_d   = col_q;
    raw_d   = raw_q;
    map_d   = map_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
`ifdef KEY_SCAN_RELEASE_EN
    push_rel = 1'b0;
`endif
    case (state_q)
      DRIVE: begin
        if (started_q) begin
          if (dwell_q == DW'(SCAN_INTV - 1)) begin
            raw_d   = ~sync2_q;
            dwell_d = '0;
            col_d   = '0;
            state_d = EVAL;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (raw_q[col_q] == map_q[k_idx]) begin
          cnt_d[k_idx] = '0;
        end else if (cnt_q[k_idx] == CW'(DEB_SCANS - 1)) begin
          cnt_d[k_idx] = '0;
          map_d[k_idx] = raw_q[col_q];
`ifdef KEY_SCAN_RELEASE_EN
          push     = 1'b1;
          push_rel = map_q[k_idx];
`else
          push     = ~map_q[k_idx];
`endif
        end else begin
          cnt_d[k_idx] = cnt_q[k_idx] + 1'b1;
        end
        if (col_q == CLW'(COLS - 1)) begin
          col_d   = '0;
          state_d = DRIVE;
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DRIVE;
      started_q <= 1'b0;
      row_q     <= '0;
      dwell_q   <= '0;
      col_q     <= '0;
      raw_q     <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      map_q     <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      raw_q     <= raw_d;
      sync1_q   <= col_in;
      sync2_q   <= sync1_q;
      map_q     <= map_d;
      cnt_q     <= cnt_d;
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop     = key_valid && key_ready;
  assign full    = (level_q == (AW + 1)'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fcode_q[wr_q] <= k_idx;
`ifdef KEY_SCAN_RELEASE_EN
      frel_q[wr_q]  <= push_rel;
`endif
    end
  end

  assign key_valid = (level_q != '0);
  assign key_code  = key_valid ? fcode_q[rd_q] : '0;
`ifdef KEY_SCAN_RELEASE_EN
  assign key_release = key_valid ? frel_q[rd_q] : 1'b0;
`else
  assign key_release = 1'b0;
`endif
  assign key_state = map_q;
  assign overflow  = ovf_q;

endmodule
